// File: rtl/operand_stack_pkg.sv
// rtl/operand_stack_pkg.sv - shared defaults and width helper for the operand stack
package operand_stack_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_DEPTH = 4;

    // Smallest n with 2**n >= v; bounded loop so it elaborates as a constant.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_stack_btn_edge.sv
// rtl/operand_stack_btn_edge.sv - button synchronizer plus rising-edge pulse generator
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   btn    : raw asynchronous button level
//   pulse  : one-cycle request, high in the cycle after the second sync stage sees the press
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       armed;
    logic [1:0] warm;

    // warm[1] marks that sync2 carries a real button sample rather than the
    // reset value. armed only rises once a genuine low level has been seen, so a
    // button held through reset release cannot fire until released and repressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            warm  <= 2'b00;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            warm  <= {warm[0], 1'b1};
            if (warm[1] && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = sync2 & ~prev & armed;

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - LIFO operand stack driven by debounced-edge push/pop buttons
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : operand written on a committed push
//   enter       : raw push button (rising edge = push request)
//   recall      : raw pop button (rising edge = pop request)
//   clear       : synchronous level flush, highest priority
//   dout        : last recalled operand, dout_valid once loaded
//   count       : stored operand count; full/empty decode it
//   overflow    : sticky, push rejected while full
//   underflow   : sticky, pop rejected while empty
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              din,
    input  logic                          enter,
    input  logic                          recall,
    input  logic                          clear,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] slots [DEPTH];
    logic [WIDTH-1:0] top;

    btn_edge u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (enter),
        .pulse (push)
    );

    btn_edge u_recall (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (recall),
        .pulse (pop)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Top-of-stack read mux, slot[count-1].
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) begin
                top = slots[i];
            end
        end
    end

    // Storage is deliberately not reset; only a lone accepted push writes it.
    // During reset push is forced low by the edge detector, so no write survives.
    always_ff @(posedge clk) begin
        if (!clear && push && !pop && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count == CW'(i)) begin
                    slots[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (push && pop) begin
            // Simultaneous push and pop forward din straight out, even when empty.
            dout       <= din;
            dout_valid <= 1'b1;
        end else if (push) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                dout       <= top;
                dout_valid <= 1'b1;
                count      <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - scoreboard bench for operand_stack
module tb_operand_stack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] din = '0;
    logic       enter = 1'b0;
    logic       recall = 1'b0;
    logic       clear = 1'b0;
    logic [8:0] dout;
    logic       dout_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    operand_stack #(.WIDTH(9), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .enter      (enter),
        .recall     (recall),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        string      name;
        logic [2:0] cnt;
        logic [8:0] dout;
        logic       dv;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    logic [2:0] m_cnt = 0;
    logic [8:0] m_dout = 0;
    logic       m_dv = 0;
    logic       m_ovf = 0;
    logic       m_unf = 0;

    task automatic expect_at(input int tag, input string name);
        exp_t e;
        e.tag   = tag;
        e.name  = name;
        e.cnt   = m_cnt;
        e.dout  = m_dout;
        e.dv    = m_dv;
        e.full  = (m_cnt == 3'd4);
        e.empty = (m_cnt == 3'd0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    task automatic set_model(input logic [2:0] c, input logic [8:0] d, input logic v,
                             input logic o, input logic u);
        m_cnt = c; m_dout = d; m_dv = v; m_ovf = o; m_unf = u;
    endtask

    // Monitor: each cycle, compare the DUT against every expectation due now.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.tag != cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d checked late at %0d", e.name, e.tag, cyc);
            end else if (count !== e.cnt || dout !== e.dout || dout_valid !== e.dv ||
                         full !== e.full || empty !== e.empty ||
                         overflow !== e.ovf || underflow !== e.unf) begin
                bad++;
                $display("FAIL %s: got cnt=%0d dout=%h dv=%b full=%b empty=%b ovf=%b unf=%b, want cnt=%0d dout=%h dv=%b full=%b empty=%b ovf=%b unf=%b",
                         e.name, count, dout, dout_valid, full, empty, overflow, underflow,
                         e.cnt, e.dout, e.dv, e.full, e.empty, e.ovf, e.unf);
            end
        end
    end

    task automatic start_press(input logic e, input logic r, input logic [8:0] d, output int k);
        @(negedge clk); #1;
        k = cyc;
        din = d; enter = e; recall = r;
        expect_at(k + 2, "latency_hold");
    endtask

    task automatic end_press();
        repeat (4) @(negedge clk);
        #1;
        enter = 1'b0; recall = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input logic e, input logic r, input logic [8:0] d, input string name,
                         input logic [2:0] c, input logic [8:0] od, input logic v,
                         input logic o, input logic u);
        int k;
        start_press(e, r, d, k);
        set_model(c, od, v, o, u);
        expect_at(k + 3, name);
        end_press();
    endtask

    task automatic do_clear();
        @(negedge clk); #1;
        clear = 1'b1;
        set_model(0, 0, 0, 0, 0);
        expect_at(cyc + 1, "clear");
        @(negedge clk); #1;
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        @(negedge clk); #1;
        expect_at(cyc + 1, "reset_state");
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        press(1, 0, 9'h005, "first_push", 1, 0, 0, 0, 0);
        do_clear();

        press(1, 0, 9'h001, "push1", 1, 0, 0, 0, 0);
        press(1, 0, 9'h002, "push2", 2, 0, 0, 0, 0);
        press(1, 0, 9'h003, "push3", 3, 0, 0, 0, 0);
        press(1, 0, 9'h004, "push4_full", 4, 0, 0, 0, 0);
        press(1, 0, 9'h1FF, "push_overflow", 4, 0, 0, 1, 0);
        press(0, 1, 9'h000, "pop4", 3, 9'h004, 1, 1, 0);
        press(0, 1, 9'h000, "pop3", 2, 9'h003, 1, 1, 0);
        press(0, 1, 9'h000, "pop2", 1, 9'h002, 1, 1, 0);
        press(0, 1, 9'h000, "pop1", 0, 9'h001, 1, 1, 0);
        do_clear();

        press(0, 1, 9'h000, "pop_underflow", 0, 0, 0, 0, 1);
        do_clear();

        press(1, 0, 9'h007, "push7", 1, 0, 0, 0, 0);
        press(1, 0, 9'h008, "push8", 2, 0, 0, 0, 0);
        press(1, 1, 9'h0AA, "both_cnt2", 2, 9'h0AA, 1, 0, 0);
        press(0, 1, 9'h000, "pop_after_both", 1, 9'h008, 1, 0, 0);
        do_clear();

        press(1, 1, 9'h033, "both_empty", 0, 9'h033, 1, 0, 0);
        do_clear();

        // Long hold yields a single push.
        start_press(1, 0, 9'h010, k);
        set_model(1, 0, 0, 0, 0);
        expect_at(k + 3, "hold_once");
        expect_at(k + 45, "hold_still_once");
        repeat (50) @(negedge clk);
        #1 enter = 1'b0;
        repeat (5) @(negedge clk);
        expect_at(cyc + 1, "hold_released");
        repeat (3) @(negedge clk);

        // Clear coinciding with the request pulse discards it.
        start_press(1, 0, 9'h020, k);
        @(negedge clk); @(negedge clk); #1;
        clear = 1'b1;
        set_model(0, 0, 0, 0, 0);
        expect_at(k + 3, "clear_kills_push");
        @(negedge clk); #1;
        clear = 1'b0;
        end_press();
        expect_at(cyc + 2, "clear_kills_push_after");
        repeat (3) @(negedge clk);

        press(1, 0, 9'h011, "push_before_rst", 1, 0, 0, 0, 0);

        // Reset coinciding with the request pulse; button stays high past release.
        start_press(1, 0, 9'h022, k);
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b0;
        set_model(0, 0, 0, 0, 0);
        expect_at(k + 3, "reset_kills_push");
        @(negedge clk); #1;
        rst_n = 1'b1;
        expect_at(k + 9, "held_through_reset");
        repeat (8) @(negedge clk);
        #1 enter = 1'b0;
        repeat (5) @(negedge clk);
        press(1, 0, 9'h012, "repress_after_reset", 1, 0, 0, 0, 0);
        press(0, 1, 9'h000, "pop_after_reset", 0, 9'h012, 1, 0, 0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked (cycle %0d)", e.name, e.tag);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
